// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: one data-memory transaction per accepted op,
// returning aligned, extended load data (or a fault) as a single-cycle response.
module lsu_mem_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [DWIDTH-1:0] mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  output logic              resp_valid_o,
  output logic [DWIDTH-1:0] resp_data_o,
  output logic              fault_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

  state_t            state, state_nxt;
  logic              is_store_p0;
  logic [2:0]        funct3_p0;
  logic [AWIDTH-1:0] addr_p0;
  logic [DWIDTH-1:0] wdata_p0;
  logic [DWIDTH-1:0] rdata_p1;
  logic              fault_p0;
  logic              accept;
  logic              fault_chk;

  // Illegal funct3 or a halfword/word access that is not naturally aligned.
  function automatic logic op_fault(input logic st, input logic [2:0] f3,
                                    input logic [1:0] off);
    logic illegal;
    logic misaligned;
    illegal    = st ? (f3 >= 3'b011)
                    : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                 ((f3[1:0] == 2'b10) && (off != 2'b00));
    return illegal || misaligned;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Select the addressed lane and extend; funct3[2] marks the unsigned variants.
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign accept    = req_valid_i && (state == IDLE);
  assign fault_chk = op_fault(is_store_i, funct3_i, addr_i[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fault_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) fault_p0 <= fault_chk;
    end
  end

  // Request capture at accept; load lane data captured on the read response.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_store_p0 <= is_store_i;
      funct3_p0   <= funct3_i;
      addr_p0     <= addr_i;
      wdata_p0    <= wdata_i;
      rdata_p1    <= '0;
    end else if (state == WAIT_RD && mem_rvalid_i) begin
      rdata_p1    <= load_extend(funct3_p0, addr_p0[1:0], mem_rdata_i);
    end
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 1'b0;
    mem_valid_o  = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_be_o     = 4'b0000;
    mem_wdata_o  = '0;
    resp_valid_o = 1'b0;
    resp_data_o  = '0;
    fault_o      = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_nxt = fault_chk ? RESP : REQ;
      end
      REQ: begin
        mem_valid_o = 1'b1;
        mem_we_o    = is_store_p0;
        mem_addr_o  = {addr_p0[AWIDTH-1:2], 2'b00};
        mem_be_o    = is_store_p0 ? store_be(funct3_p0, addr_p0[1:0]) : 4'b1111;
        mem_wdata_o = is_store_p0 ? store_lanes(funct3_p0, wdata_p0) : '0;
        if (mem_ready_i) state_nxt = is_store_p0 ? RESP : WAIT_RD;
      end
      WAIT_RD: begin
        if (mem_rvalid_i) state_nxt = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_data_o  = rdata_p1;
        fault_o      = fault_p0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: responses checked against a queue of
// expected {data, fault} pushed when each request is driven.
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, req_ready_o, is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        mem_valid_o, mem_ready_i, mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_data_o;
  logic        fault_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } resp_t;
  resp_t sb[$];

  lsu_mem_stage dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .is_store_i(is_store_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o),
    .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid_o pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid_o) begin
      if (sb.size() == 0) begin
        check_bit("unexpected_resp", resp_valid_o, 1'b0);
      end else begin
        resp_t e;
        e = sb.pop_front();
        check("resp_data", resp_data_o, e.data);
        check_bit("resp_fault", fault_o, e.fault);
      end
    end else if (!reset) begin
      check("idle_resp_data", resp_data_o, 32'h0);
      check_bit("idle_fault", fault_o, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d);
    req_valid_i = 1'b1;
    is_store_i  = st;
    funct3_i    = f3;
    addr_i      = a;
    wdata_i     = d;
  endtask

  // Load with immediate grant; rvalid arrives the cycle after the grant.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rd, input logic [31:0] exp, input logic early_rv);
    sb.push_back('{data: exp, fault: 1'b0});
    drive_req(1'b0, f3, a, 32'h0);
    mem_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    check_bit({tag, "_mem_valid"}, mem_valid_o, 1'b1);
    check_bit({tag, "_we"}, mem_we_o, 1'b0);
    check({tag, "_be"}, {28'h0, mem_be_o}, 32'hF);
    check({tag, "_addr"}, mem_addr_o, {a[31:2], 2'b00});
    if (early_rv) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hFFFF_FFFF;
    end
    step();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;
    check_bit({tag, "_grant_drop"}, mem_valid_o, 1'b0);
    check_bit({tag, "_wait_resp"}, resp_valid_o, 1'b0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    step();
    mem_rvalid_i = 1'b0;
    check_bit({tag, "_resp_valid"}, resp_valid_o, 1'b1);
    step();
    check_bit({tag, "_back_idle"}, req_ready_o, 1'b1);
  endtask

  task automatic do_fault(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] a);
    sb.push_back('{data: 32'h0, fault: 1'b1});
    drive_req(st, f3, a, 32'h1234_5678);
    mem_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    check_bit({tag, "_no_mem"}, mem_valid_o, 1'b0);
    check_bit({tag, "_resp_valid"}, resp_valid_o, 1'b1);
    step();
    mem_ready_i = 1'b0;
    check_bit({tag, "_one_pulse"}, resp_valid_o, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid_i = 1'b0; is_store_i = 1'b0; funct3_i = 3'b000;
    addr_i = 32'h0; wdata_i = 32'h0;
    mem_ready_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    step(); step();
    reset = 1'b0;

    check_bit("rst_req_ready", req_ready_o, 1'b1);
    check_bit("rst_mem_valid", mem_valid_o, 1'b0);
    check_bit("rst_we", mem_we_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_be", {28'h0, mem_be_o}, 32'h0);
    check("rst_wdata", mem_wdata_o, 32'h0);
    check_bit("rst_resp_valid", resp_valid_o, 1'b0);

    // SW with immediate grant
    sb.push_back('{data: 32'h0, fault: 1'b0});
    drive_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
    mem_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    check_bit("sw_mem_valid", mem_valid_o, 1'b1);
    check_bit("sw_we", mem_we_o, 1'b1);
    check("sw_addr", mem_addr_o, 32'h100);
    check("sw_be", {28'h0, mem_be_o}, 32'hF);
    check("sw_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    check_bit("sw_busy", req_ready_o, 1'b0);
    step();
    mem_ready_i = 1'b0;
    check_bit("sw_resp_valid", resp_valid_o, 1'b1);
    step();
    check_bit("sw_idle", req_ready_o, 1'b1);

    // SB at byte 3 with grant delayed 3 cycles; inputs scrambled after accept
    sb.push_back('{data: 32'h0, fault: 1'b0});
    drive_req(1'b1, 3'b000, 32'h103, 32'h0000_00A5);
    step();
    drive_req(1'b1, 3'b010, 32'hFFC, 32'h5A5A_5A5A);
    req_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_bit("sb_hold_valid", mem_valid_o, 1'b1);
      check_bit("sb_hold_we", mem_we_o, 1'b1);
      check("sb_hold_addr", mem_addr_o, 32'h100);
      check("sb_hold_be", {28'h0, mem_be_o}, 32'h8);
      check("sb_hold_wdata", mem_wdata_o, 32'hA5A5_A5A5);
      check_bit("sb_hold_noresp", resp_valid_o, 1'b0);
      if (i == 3) mem_ready_i = 1'b1;
      step();
    end
    mem_ready_i = 1'b0;
    check_bit("sb_resp_valid", resp_valid_o, 1'b1);
    step();

    // SH to upper half
    sb.push_back('{data: 32'h0, fault: 1'b0});
    drive_req(1'b1, 3'b001, 32'h122, 32'h0000_BEEF);
    step();
    req_valid_i = 1'b0;
    check("sh_be", {28'h0, mem_be_o}, 32'hC);
    check("sh_wdata", mem_wdata_o, 32'hBEEF_BEEF);
    mem_ready_i = 1'b1;
    step();
    mem_ready_i = 1'b0;
    step();

    // Loads from lane 2 of 0x12803456; LH also sees an rvalid alongside its grant
    do_load("lb",  3'b000, 32'h202, 32'h1280_3456, 32'hFFFF_FF80, 1'b0);
    do_load("lbu", 3'b100, 32'h202, 32'h1280_3456, 32'h0000_0080, 1'b0);
    do_load("lh",  3'b001, 32'h202, 32'h1280_3456, 32'h0000_1280, 1'b1);
    do_load("lhu", 3'b101, 32'h200, 32'h1280_F456, 32'h0000_F456, 1'b0);
    do_load("lw",  3'b010, 32'h204, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);

    // Faults: misaligned and illegal funct3
    do_fault("lw_mis",  1'b0, 3'b010, 32'h006);
    do_fault("ld_ill",  1'b0, 3'b011, 32'h000);
    do_fault("sh_mis",  1'b1, 3'b001, 32'h101);
    do_fault("st_ill",  1'b1, 3'b100, 32'h000);

    // Reset while waiting for read data, then a stray rvalid
    drive_req(1'b0, 3'b010, 32'h300, 32'h0);
    mem_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    mem_ready_i = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_bit("mid_rst_ready", req_ready_o, 1'b1);
    check_bit("mid_rst_mem_valid", mem_valid_o, 1'b0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h8765_4321;
    step();
    mem_rvalid_i = 1'b0;
    check_bit("stray_rv_noresp", resp_valid_o, 1'b0);
    step();
    check_bit("stray_rv_noresp2", resp_valid_o, 1'b0);
    check_bit("stray_rv_ready", req_ready_o, 1'b1);

    // Back-to-back: req_valid_i held through SW then LW
    sb.push_back('{data: 32'h0, fault: 1'b0});
    drive_req(1'b1, 3'b010, 32'h400, 32'h1122_3344);
    mem_ready_i = 1'b1;
    step();
    check_bit("b2b_busy_req", req_ready_o, 1'b0);
    drive_req(1'b0, 3'b010, 32'h404, 32'h0);
    sb.push_back('{data: 32'h5566_7788, fault: 1'b0});
    step();
    check_bit("b2b_busy_resp", req_ready_o, 1'b0);
    check_bit("b2b_sw_resp", resp_valid_o, 1'b1);
    step();
    check_bit("b2b_idle_ready", req_ready_o, 1'b1);
    check_bit("b2b_not_yet", mem_valid_o, 1'b0);
    step();
    req_valid_i = 1'b0;
    check_bit("b2b_lw_valid", mem_valid_o, 1'b1);
    check("b2b_lw_addr", mem_addr_o, 32'h404);
    check_bit("b2b_lw_we", mem_we_o, 1'b0);
    step();
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h5566_7788;
    step();
    mem_rvalid_i = 1'b0;
    check_bit("b2b_lw_resp", resp_valid_o, 1'b1);
    step();
    step();

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Memory-stage load/store unit sitting downstream of the execute ALU.
- Accepts the ALU-computed effective address plus the rs2 store data and the load/store funct3 from execute.
- Performs one data-memory transaction over a valid/ready request channel with a separate read-response channel.
- Returns aligned, sign/zero-extended load data, or a fault, to writeback.

Parameters:
DWIDTH, 32, data width (only 32 supported)
AWIDTH, 32, address width

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid_i  in  1  execute presents a memory op this cycle
req_ready_o  out  1  unit can accept a request (IDLE only)
is_store_i  in  1  1=store, 0=load
funct3_i  in  3  RV32I load/store funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr_i  in  AWIDTH  effective address (ALU res_o)
wdata_i  in  DWIDTH  rs2 store data
mem_valid_o  out  1  request to data memory
mem_ready_i  in  1  memory accepts request
mem_we_o  out  1  write enable
mem_addr_o  out  AWIDTH  word-aligned address {addr[31:2],2'b00}
mem_be_o  out  4  byte enables
mem_wdata_o  out  DWIDTH  lane-replicated store data
mem_rvalid_i  in  1  read data valid
mem_rdata_i  in  DWIDTH  read word
resp_valid_o  out  1  one-cycle completion pulse
resp_data_o  out  DWIDTH  extended load data (0 for stores/faults)
fault_o  out  1  misaligned or illegal funct3, qualified by resp_valid_o

Behaviour:
- States: IDLE, REQ, WAIT_RD, RESP. Reset: state=IDLE; every output 0 except req_ready_o=1.
- req_ready_o = (state==IDLE). Accept on req_valid_i && req_ready_o; register is_store, funct3, addr, wdata.
- Fault check at accept:
  - Illegal funct3: loads 011/110/111; stores >=011.
  - Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
  - On fault: IDLE->RESP with fault_o=1, resp_data_o=0, no memory access.
- Legal op: IDLE->REQ. mem_valid_o=1 first cycle after accept.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o stay stable until mem_ready_i is seen.
- REQ with mem_ready_i=1: store -> RESP; load -> WAIT_RD.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111, wdata unchanged.
- Loads: mem_we_o=0, mem_be_o=1111.
- WAIT_RD:
  - On mem_rvalid_i, capture the lane selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Then -> RESP.
  - mem_rvalid_i is ignored in every other state, including a same-cycle rvalid with grant in REQ.
- RESP: resp_valid_o=1 for exactly one cycle, with resp_data_o and fault_o valid; then -> IDLE. No backpressure on the response.
- Minimum latency from accept to resp_valid_o:
  - Store with immediate grant: 2 cycles.
  - Load with grant and rvalid the next cycle: 3 cycles.
  - Fault: 1 cycle.
- No timeouts: a stalled mem_ready_i or mem_rvalid_i holds the unit in REQ or WAIT_RD indefinitely.
- req_valid_i outside IDLE is ignored; the upstream holds it.
- Reset mid-transaction:
  - Next cycle is IDLE with outputs at reset values; mem_valid_o drops immediately.
  - A later stray mem_rvalid_i is ignored.
- resp_data_o and fault_o hold 0 outside RESP.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, mem_ready_i=1 on first REQ cycle -> mem_addr_o=0x100, be=1111, we=1; resp_valid_o 2 cycles after accept, fault_o=0.
- SB addr=0x103, wdata=0x000000A5, mem_ready_i delayed 3 cycles -> be=1000, wdata=0xA5A5A5A5, mem_valid_o and all request fields held stable for 4 cycles.
- LB addr=0x202, rdata=0x12_80_34_56 -> resp_data_o=0xFFFFFF80. LBU same -> 0x00000080. LH addr=0x202 -> 0x00001280.
- LW addr=0x006 -> no mem_valid_o, resp_valid_o 1 cycle after accept, fault_o=1. Load funct3=3'b011 -> same fault response.
- Load accepted and granted, reset asserted in WAIT_RD, then mem_rvalid_i pulses -> no resp_valid_o, req_ready_o=1 the cycle after reset.
- Back-to-back: req_valid_i held high for SW then LW -> second request accepted only in the cycle after RESP; req_ready_o=0 throughout the first operation.
